cursor_turn_ctrl: RTL
=====================

# cursor_turn_ctrl

Sequencing controller for the tic-tac-toe play field. It converts debounced player buttons into the 4-bit cell index (`move`, 0–8) that drives the cursor overlay. It also holds board occupancy, alternates players X/O, and commits placements. It sits between the button synchronizers and the VGA overlay/mark renderers, and feeds the win checker, which answers with `game_over`.

## Interface
Parameters:
- `BLINK_CYCLES`, 12_500_000: half-period of cursor blink in clocks. Used only with blink compiled in; minimum 2.

Ports:
- `clk`  in  1  pixel/system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  level; starts or restarts a game from IDLE/DONE
- `btn_next`  in  1  debounced level; move cursor forward
- `btn_prev`  in  1  debounced level; move cursor backward
- `btn_sel`  in  1  debounced level; place mark at cursor
- `game_over`  in  1  level from win checker
- `move`  out  4  cursor cell index 0–8; 4'hF = no cursor
- `cursor_en`  out  1  cursor display enable
- `player`  out  1  side to move; 0 = X, 1 = O
- `board_x`  out  9  X occupancy, bit i = cell i
- `board_o`  out  9  O occupancy
- `place_valid`  out  1  one-cycle pulse on a committed placement
- `place_cell`  out  4  cell of the last placement; held until the next one
- `state_done`  out  1  high in DONE

## Operation
- States: IDLE → PLAY → DONE → PLAY.
- IDLE:
  - `move`=4'hF, `cursor_en`=0.
  - `start` clears the boards, sets `move`=0 and `player`=0, and enters PLAY.
- PLAY, button handling:
  - Each button acts on its rising edge only. The previous level is registered internally.
  - Priority when edges coincide: `btn_sel` > `btn_next` > `btn_prev`. Only one action per cycle.
- Next/prev:
  - Cursor jumps to the nearest unoccupied cell in that direction, skipping occupied cells.
  - Wrap-around: 8→0 forward, 0→8 backward.
  - If no other free cell exists, `move` is unchanged.
- Select on a free cell:
  - Set the player's board bit.
  - Pulse `place_valid` and load `place_cell`=`move`.
  - Toggle `player`.
  - Move the cursor to the next free cell forward, with wrap.
- Select on an occupied cell: no effect and no pulse. This cannot occur via navigation but must be handled.
- Leaving PLAY for DONE:
  - If a placement fills all 9 cells, go to DONE on the same edge.
  - `game_over`=1 in PLAY goes to DONE. It takes priority over any button edge in the same cycle; that placement is dropped.
- DONE:
  - `move`=4'hF, `cursor_en`=0.
  - Boards and `player` hold.
  - `start` restarts exactly as from IDLE.
- `start` in PLAY is ignored.

## Timing
- Reset values: state IDLE, `move`=4'hF, `cursor_en`=0, `player`=0, `board_x`=`board_o`=0, `place_valid`=0, `place_cell`=4'hF, `state_done`=0.
- Reset during PLAY discards the game, takes effect on the next edge, and asserts no `place_valid`.
- All outputs are registered.
- A button first sampled high at edge N (low at N-1) gives updated outputs after edge N. Latency is 1 clock.
- A level held high acts once. It must return low for at least one sampled cycle before it can act again.
- `place_valid` is high for exactly the cycle following the committing edge.
- `board_*`, `player` and `move` update on that same edge.
- `game_over` is sampled each edge. The board is externally evaluated 1+ cycles after `place_valid`, and a next-move edge arriving in that window is legal.
- Free-cell search is combinational over 9 cells within one cycle.

## Configuration
- `CURSOR_BLINK_EN` defined:
  - In PLAY, `cursor_en` toggles every `BLINK_CYCLES` clocks.
  - The counter reloads and `cursor_en` forces 1 on any `move` change and on entry to PLAY.
- Undefined: `cursor_en` = 1 throughout PLAY, with no counter logic.

## Structure
- `tictactoe_pkg` holds:
  - state enum
  - `NUM_CELLS`=9
  - `CELL_NONE`=4'hF
  - `cell_t` (logic [3:0])
  - `player_t`
- Sub-module `free_cell_search`: inputs occupancy[8:0], current cell and direction; outputs the next free cell and a found flag. It is purely combinational and instantiated once, with the direction muxed by priority.

## Test plan
- Reset, `start`, press next 3× → `move` 0→1→2→3; press prev at 0 → `move`=8 (wrap).
- `start`, sel at 0 → `board_x`=9'h001, `place_valid` 1 cycle, `place_cell`=0, `player`=1, `move`=1. Then prev from 1 → `move`=8 (skips 0).
- Edges on sel and next in the same cycle at cell 4 → placement at 4 only. Held sel for 10 cycles → exactly one `place_valid`.
- Fill 9 cells alternately → after the 9th, `state_done`=1, `move`=4'hF, `board_x|board_o`=9'h1FF. `start` → boards 0, `move`=0, `player`=0.
- `game_over` and sel edge in the same cycle → DONE, no `place_valid`, boards unchanged. `rst_n`=0 mid-game → all reset values next edge.
- With `CURSOR_BLINK_EN` and `BLINK_CYCLES`=4 → `cursor_en` toggles every 4 clocks. A next press forces `cursor_en`=1 and restarts the count.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe play-field logic.
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;

  typedef logic [3:0] cell_t;
  localparam cell_t CELL_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    PLAYER_X = 1'b0,
    PLAYER_O = 1'b1
  } player_t;

  // One-hot mask of a cell; all-zero for CELL_NONE or any out-of-range index.
  function automatic logic [NUM_CELLS-1:0] cell_mask(input cell_t c);
    logic [NUM_CELLS-1:0] m;
    m = '0;
    if (c < cell_t'(NUM_CELLS)) m[c] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/free_cell_search.sv
// Combinational search for the nearest unoccupied cell after i_cell, in either
// direction with wrap-around; i_cell itself is never returned.
module free_cell_search
  import tictactoe_pkg::*;
(
  input  logic [NUM_CELLS-1:0] i_occupancy,
  input  cell_t                i_cell,
  input  logic                 i_dir_fwd,
  output cell_t                o_next_cell,
  output logic                 o_found
);

  logic [4:0] w_idx;

  always_comb begin
    o_next_cell = i_cell;
    o_found     = 1'b0;
    w_idx       = '0;
    // Backward steps are taken as forward steps of NUM_CELLS-k, modulo NUM_CELLS.
    for (int k = 1; k < NUM_CELLS; k++) begin
      w_idx = i_dir_fwd ? (5'(i_cell) + 5'(k)) : (5'(i_cell) + 5'(NUM_CELLS - k));
      if (w_idx >= 5'(NUM_CELLS)) w_idx = w_idx - 5'(NUM_CELLS);
      if (!o_found && (w_idx < 5'(NUM_CELLS)) && !i_occupancy[w_idx[3:0]]) begin
        o_found     = 1'b1;
        o_next_cell = w_idx[3:0];
      end
    end
  end

endmodule

// File: rtl/cursor_turn_ctrl.sv
// Cursor/turn sequencer for the tic-tac-toe field: button edges move the cursor,
// commit marks and alternate players. Optional cursor blink via CURSOR_BLINK_EN.
module cursor_turn_ctrl
  import tictactoe_pkg::*;
#(
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_sel,
  input  logic       game_over,
  output logic [3:0] move,
  output logic       cursor_en,
  output logic       player,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       place_valid,
  output logic [3:0] place_cell,
  output logic       state_done
);

  if (BLINK_CYCLES < 2) begin : g_bad_blink
    $error("BLINK_CYCLES must be at least 2");
  end

  state_t     r_state, w_state_next;
  cell_t      r_move, w_move_next, r_place_cell, w_place_cell_next;
  player_t    r_player, w_player_next;
  logic [8:0] r_board_x, w_board_x_next, r_board_o, w_board_o_next;
  logic       r_place_valid, w_place_valid_next, r_state_done, r_cursor_en;
  logic       r_next_d, r_prev_d, r_sel_d;
  logic       w_next_rise, w_prev_rise, w_sel_rise;
  logic [8:0] w_occupied, w_move_mask, w_search_occ;
  logic       w_cell_free, w_act_ok, w_do_sel, w_do_next, w_do_prev, w_restart;
  cell_t      w_found_cell;
  logic       w_found;

  assign w_next_rise = btn_next & ~r_next_d;
  assign w_prev_rise = btn_prev & ~r_prev_d;
  assign w_sel_rise  = btn_sel  & ~r_sel_d;

  assign w_occupied  = r_board_x | r_board_o;
  assign w_move_mask = cell_mask(r_move);
  assign w_cell_free = (|w_move_mask) && !(|(w_occupied & w_move_mask));

  // A select edge claims the cycle even when it lands on an occupied cell.
  assign w_act_ok  = (r_state == ST_PLAY) && !game_over;
  assign w_do_sel  = w_act_ok && w_sel_rise && w_cell_free;
  assign w_do_next = w_act_ok && !w_sel_rise && w_next_rise;
  assign w_do_prev = w_act_ok && !w_sel_rise && !w_next_rise && w_prev_rise;
  assign w_restart = (r_state != ST_PLAY) && start;

  // After a placement, search with the new mark already counted as occupied.
  assign w_search_occ = w_do_sel ? (w_occupied | w_move_mask) : w_occupied;

  free_cell_search u_search (
    .i_occupancy (w_search_occ),
    .i_cell      (r_move),
    .i_dir_fwd   (!w_do_prev),
    .o_next_cell (w_found_cell),
    .o_found     (w_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_next = ST_PLAY;
      ST_PLAY: begin
        if (game_over)                w_state_next = ST_DONE;
        else if (w_do_sel && !w_found) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_move_next        = r_move;
    w_player_next      = r_player;
    w_board_x_next     = r_board_x;
    w_board_o_next     = r_board_o;
    w_place_valid_next = 1'b0;
    w_place_cell_next  = r_place_cell;
    if (w_restart) begin
      w_move_next    = cell_t'(0);
      w_player_next  = PLAYER_X;
      w_board_x_next = '0;
      w_board_o_next = '0;
    end else if (w_do_sel) begin
      if (r_player == PLAYER_O) w_board_o_next = r_board_o | w_move_mask;
      else                      w_board_x_next = r_board_x | w_move_mask;
      w_player_next      = (r_player == PLAYER_O) ? PLAYER_X : PLAYER_O;
      w_place_valid_next = 1'b1;
      w_place_cell_next  = r_move;
      w_move_next        = w_found_cell;
    end else if ((w_do_next || w_do_prev) && w_found) begin
      w_move_next = w_found_cell;
    end
    if (w_state_next == ST_DONE) w_move_next = CELL_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_move        <= CELL_NONE;
      r_player      <= PLAYER_X;
      r_board_x     <= '0;
      r_board_o     <= '0;
      r_place_valid <= 1'b0;
      r_place_cell  <= CELL_NONE;
      r_state_done  <= 1'b0;
      r_next_d      <= 1'b0;
      r_prev_d      <= 1'b0;
      r_sel_d       <= 1'b0;
    end else begin
      r_move        <= w_move_next;
      r_player      <= w_player_next;
      r_board_x     <= w_board_x_next;
      r_board_o     <= w_board_o_next;
      r_place_valid <= w_place_valid_next;
      r_place_cell  <= w_place_cell_next;
      r_state_done  <= (w_state_next == ST_DONE);
      r_next_d      <= btn_next;
      r_prev_d      <= btn_prev;
      r_sel_d       <= btn_sel;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  logic [BLINK_W-1:0] r_blink_cnt;

  // Blink phase restarts (visible) on PLAY entry and whenever the cursor moves.
  always_ff @(posedge clk) begin
    if (!rst_n || (w_state_next != ST_PLAY)) begin
      r_blink_cnt <= '0;
      r_cursor_en <= 1'b0;
    end else if ((r_state != ST_PLAY) || (w_move_next != r_move)) begin
      r_blink_cnt <= '0;
      r_cursor_en <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_cursor_en <= ~r_cursor_en;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) r_cursor_en <= 1'b0;
    else        r_cursor_en <= (w_state_next == ST_PLAY);
  end
`endif

  assign move        = r_move;
  assign cursor_en   = r_cursor_en;
  assign player      = r_player;
  assign board_x     = r_board_x;
  assign board_o     = r_board_o;
  assign place_valid = r_place_valid;
  assign place_cell  = r_place_cell;
  assign state_done  = r_state_done;

endmodule
